// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and default width.
package shift_add_multiplier_pkg;

    localparam int unsigned N_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/n_bit_adder.sv
// Combinational N-bit adder with carry in and carry out.
module n_bit_adder #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N multiplier, one shift-and-add step per clock
// through a single shared n_bit_adder instance.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CNT_W = $clog2(N);

    state_t             state_q;
    state_t             state_d;
    logic   [N-1:0]     m_q;
    logic   [N-1:0]     q_q;
    logic   [N-1:0]     acc_q;
    logic   [CNT_W-1:0] cnt_q;
    logic               load;
    logic               step;
    logic               last;

    logic   [N-1:0]     add_b;
    logic   [N-1:0]     sum;
    logic               cout;
    logic   [N-1:0]     acc_next;
    logic   [N-1:0]     q_next;

    // Partial product: add the multiplicand only when the current multiplier LSB is set.
    assign add_b = q_q[0] ? m_q : '0;

    n_bit_adder #(.N(N)) u_adder (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // {cout, sum, Q} shifted right by one; cout becomes the new ACC MSB.
    assign acc_next = {cout, sum[N-1:1]};
    assign q_next   = {sum[0], q_q[N-1:1]};

    // Next-state and step control.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state_q <= state_d;
            ready   <= (state_d == ST_IDLE);
            done    <= (state_d == ST_DONE);
            if (load) begin
                m_q   <= a;
                q_q   <= b;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (step) begin
                acc_q <= acc_next;
                q_q   <= q_next;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (last) begin
                product <= {acc_next, q_next};
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed vectors, random operands
// against an arithmetic reference, and multi-cycle corner sequences.
module tb_shift_add_multiplier;

    localparam int unsigned N = 16;
    localparam int unsigned LAT = N + 1;
    localparam int unsigned PERIOD = N + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           ready;
    logic           done;
    logic [2*N-1:0] product;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    shift_add_multiplier #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        longint unsigned p;
        p = longint'(x) * longint'(y);
        return (2*N)'(p);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full transaction from an idle DUT; checks latency, result, handshake.
    task automatic do_mult(input logic [N-1:0] x, input logic [N-1:0] y,
                           input logic [2*N-1:0] exp, input string tag);
        int  edges;
        bit  seen;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        check({tag, "_ready_low"}, 64'(ready), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(edges), 64'(LAT));
        check({tag, "_product"}, 64'(product), 64'(exp));
        check({tag, "_ready_in_done"}, 64'(ready), 64'd0);
        @(negedge clk);
        check({tag, "_done_single"}, 64'(done), 64'd0);
        check({tag, "_ready_back"}, 64'(ready), 64'd1);
        check({tag, "_held"}, 64'(product), 64'(exp));
    endtask

    initial begin
        int dones;
        int t_prev;
        logic [2*N-1:0] got;

        vecs[0] = '{a: 16'd3,      b: 16'd5,      exp: 32'h0000_000F};
        vecs[1] = '{a: 16'hFFFF,   b: 16'hFFFF,   exp: 32'hFFFE_0001};
        vecs[2] = '{a: 16'h0000,   b: 16'h1234,   exp: 32'h0000_0000};
        vecs[3] = '{a: 16'h1234,   b: 16'h0000,   exp: 32'h0000_0000};
        vecs[4] = '{a: 16'h0001,   b: 16'hFFFF,   exp: 32'h0000_FFFF};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);

        for (int i = 0; i < 5; i++)
            do_mult(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            logic [N-1:0] x, y;
            x = N'($urandom);
            y = N'($urandom);
            do_mult(x, y, ref_mul(x, y), $sformatf("rnd%0d", i));
        end

        // Start during RUN is ignored and operands may change freely.
        @(negedge clk);
        a = 16'd7; b = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 16'd2; b = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hABCD; b = 16'h5555;
        dones = 0; got = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                got = product;
            end
        end
        check("ignore_done_count", 64'(dones), 64'd1);
        check("ignore_product", 64'(got), 64'd63);
        check("ignore_ready", 64'(ready), 64'd1);

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        a = 16'd100; b = 16'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_product", 64'(product), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        do_mult(16'd100, 16'd200, 32'd20000, "after_rst");

        // Continuous start: back-to-back results with fixed spacing.
        @(negedge clk);
        a = 16'd12; b = 16'd12; start = 1'b1;
        dones = 0; t_prev = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) begin
                check($sformatf("hold_product%0d", dones), 64'(product), 64'd144);
                if (dones > 0)
                    check($sformatf("hold_spacing%0d", dones), 64'(cyc - t_prev), 64'(PERIOD));
                t_prev = cyc;
                dones++;
            end
        end
        check("hold_done_count", 64'(dones), 64'd3);
        start = 1'b0;
        repeat (25) @(negedge clk);
        check("final_ready", 64'(ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
